axi_mux_nm: RTL and testbench

AXI_MUX_NM -- requirements
Module: axi_mux_nm

---
 rtl/axi_mux_nm_pkg.sv | 42 ++++
 rtl/axi_bus_if.sv | 49 ++++
 rtl/axi_mux_nm_out_cnt.sv | 49 ++++
 rtl/axi_mux_nm.sv | 208 ++++++++++++++++++++
 tb/tb_axi_mux_nm.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mux_nm_pkg.sv
// ============================================================================
// Module      : axi_mux_nm_pkg
// Description : Shared types for the N:1 AXI port mux (FSM state, soft-reg
//               request/response, bus widths, counter-width helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_mux_nm_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;
    localparam int SR_AW  = 32;
    localparam int SR_DW  = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } axi_mux_state_t;

    typedef struct packed {
        logic             valid;
        logic             write;
        logic [SR_AW-1:0] addr;
        logic [SR_DW-1:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic             valid;
        logic [SR_DW-1:0] data;
    } SoftRegResp;

    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_bus_if.sv
// ============================================================================
// Module      : axi_bus_t
// Description : Reduced AXI bus. The "master" modport is the view of a port
//               that a master attaches to; "slave" drives a downstream slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_bus_t;
    import axi_mux_nm_pkg::*;

    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [ID_W-1:0]   arid;
    logic              rvalid, rready, rlast;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic [ID_W-1:0]   rid;
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [ID_W-1:0]   awid;
    logic              wvalid, wready, wlast;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;

    modport master (
        input  arvalid, araddr, arlen, arid, rready,
        input  awvalid, awaddr, awlen, awid,
        input  wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rdata, rresp, rid, rlast,
        output awready, wready, bvalid, bresp, bid
    );

    modport slave (
        output arvalid, araddr, arlen, arid, rready,
        output awvalid, awaddr, awlen, awid,
        output wvalid, wdata, wstrb, wlast, bready,
        input  arready, rvalid, rdata, rresp, rid, rlast,
        input  awready, wready, bvalid, bresp, bid
    );

endinterface

`default_nettype wire

// File: rtl/axi_mux_nm_out_cnt.sv
// ============================================================================
// Module      : axi_mux_out_cnt
// Description : Saturating up/down outstanding-transaction counter with
//               zero and full flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_mux_out_cnt #(
    parameter int WIDTH = 5,
    parameter int MAX   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_o,
    output logic             full_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign zero_o = (cnt_q == '0);
    assign full_o = (cnt_q == WIDTH'(MAX));
    assign cnt_o  = cnt_q;

    // Simultaneous inc/dec cancels; saturate instead of wrapping at either end.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !full_o) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_mux_nm.sv
// ============================================================================
// Module      : axi_mux_nm
// Description : N:1 AXI port mux with soft-register selected port and safe
//               drain-before-switch. Optional status read: AXI_MUX_NM_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_mux_nm
    import axi_mux_nm_pkg::*;
#(
    parameter int               N_MASTERS       = 4,
    parameter logic [SR_AW-1:0] SR_ADDR         = 'h10,
    parameter int               MAX_OUTSTANDING = 16,
    parameter int               RESET_SEL       = 0,
    localparam int              SELW            = $clog2(N_MASTERS)
) (
    input  logic            clk,
    input  logic            rst,
    input  SoftRegReq       sr_req,
    output SoftRegResp      sr_resp,
    axi_bus_t.master        axi_m [N_MASTERS],
    axi_bus_t.slave         axi_s,
    output logic [SELW-1:0] cur_sel,
    output logic            busy
);

    localparam int CW = cnt_width(MAX_OUTSTANDING);

    axi_mux_state_t  state_q;
    logic [SELW-1:0] cur_sel_q, pend_sel_q;
    logic            pend_valid_q, busy_q;

    logic              w_arvalid [N_MASTERS];
    logic [ADDR_W-1:0] w_araddr  [N_MASTERS];
    logic [LEN_W-1:0]  w_arlen   [N_MASTERS];
    logic [ID_W-1:0]   w_arid    [N_MASTERS];
    logic              w_rready  [N_MASTERS];
    logic              w_awvalid [N_MASTERS];
    logic [ADDR_W-1:0] w_awaddr  [N_MASTERS];
    logic [LEN_W-1:0]  w_awlen   [N_MASTERS];
    logic [ID_W-1:0]   w_awid    [N_MASTERS];
    logic              w_wvalid  [N_MASTERS];
    logic [DATA_W-1:0] w_wdata   [N_MASTERS];
    logic [DATA_W/8-1:0] w_wstrb [N_MASTERS];
    logic              w_wlast   [N_MASTERS];
    logic              w_bready  [N_MASTERS];

    logic [CW-1:0] w_rd_cnt, w_b_cnt, w_w_cnt;
    logic          w_rd_zero, w_b_zero, w_w_zero;
    logic          w_rd_full, w_b_full, w_w_full;
    logic          w_ar_en, w_aw_en, w_w_en;
    logic          w_ar_hs, w_r_last_hs, w_aw_hs, w_w_last_hs, w_b_hs;
    logic          w_sr_hit, w_sel_wr, w_drained;
    logic [SELW-1:0] w_new_sel;

    // Address channels open only in RUN and below the outstanding limit;
    // W is held back until an accepted AW is waiting for its data.
    assign w_ar_en = (state_q == RUN) && !w_rd_full;
    assign w_aw_en = (state_q == RUN) && !w_b_full && !w_w_full;
    assign w_w_en  = !w_w_zero;

    assign w_ar_hs     = axi_s.arvalid && axi_s.arready;
    assign w_r_last_hs = axi_s.rvalid && axi_s.rready && axi_s.rlast;
    assign w_aw_hs     = axi_s.awvalid && axi_s.awready;
    assign w_w_last_hs = axi_s.wvalid && axi_s.wready && axi_s.wlast;
    assign w_b_hs      = axi_s.bvalid && axi_s.bready;
    assign w_drained   = w_rd_zero && w_b_zero && w_w_zero;

    generate
        for (genvar i = 0; i < N_MASTERS; i++) begin : g_port
            logic w_sel;
            assign w_sel = (cur_sel_q == SELW'(i));

            assign w_arvalid[i] = axi_m[i].arvalid;
            assign w_araddr[i]  = axi_m[i].araddr;
            assign w_arlen[i]   = axi_m[i].arlen;
            assign w_arid[i]    = axi_m[i].arid;
            assign w_rready[i]  = axi_m[i].rready;
            assign w_awvalid[i] = axi_m[i].awvalid;
            assign w_awaddr[i]  = axi_m[i].awaddr;
            assign w_awlen[i]   = axi_m[i].awlen;
            assign w_awid[i]    = axi_m[i].awid;
            assign w_wvalid[i]  = axi_m[i].wvalid;
            assign w_wdata[i]   = axi_m[i].wdata;
            assign w_wstrb[i]   = axi_m[i].wstrb;
            assign w_wlast[i]   = axi_m[i].wlast;
            assign w_bready[i]  = axi_m[i].bready;

            assign axi_m[i].arready = w_sel && w_ar_en && axi_s.arready;
            assign axi_m[i].rvalid  = w_sel && axi_s.rvalid;
            assign axi_m[i].rdata   = w_sel ? axi_s.rdata : '0;
            assign axi_m[i].rresp   = w_sel ? axi_s.rresp : '0;
            assign axi_m[i].rid     = w_sel ? axi_s.rid   : '0;
            assign axi_m[i].rlast   = w_sel && axi_s.rlast;
            assign axi_m[i].awready = w_sel && w_aw_en && axi_s.awready;
            assign axi_m[i].wready  = w_sel && w_w_en && axi_s.wready;
            assign axi_m[i].bvalid  = w_sel && axi_s.bvalid;
            assign axi_m[i].bresp   = w_sel ? axi_s.bresp : '0;
            assign axi_m[i].bid     = w_sel ? axi_s.bid   : '0;
        end
    endgenerate

    assign axi_s.arvalid = w_ar_en && w_arvalid[cur_sel_q];
    assign axi_s.araddr  = w_araddr[cur_sel_q];
    assign axi_s.arlen   = w_arlen[cur_sel_q];
    assign axi_s.arid    = w_arid[cur_sel_q];
    assign axi_s.rready  = w_rready[cur_sel_q];
    assign axi_s.awvalid = w_aw_en && w_awvalid[cur_sel_q];
    assign axi_s.awaddr  = w_awaddr[cur_sel_q];
    assign axi_s.awlen   = w_awlen[cur_sel_q];
    assign axi_s.awid    = w_awid[cur_sel_q];
    assign axi_s.wvalid  = w_w_en && w_wvalid[cur_sel_q];
    assign axi_s.wdata   = w_wdata[cur_sel_q];
    assign axi_s.wstrb   = w_wstrb[cur_sel_q];
    assign axi_s.wlast   = w_wlast[cur_sel_q];
    assign axi_s.bready  = w_bready[cur_sel_q];

    axi_mux_out_cnt #(.WIDTH(CW), .MAX(MAX_OUTSTANDING)) u_rd_cnt (
        .clk(clk), .rst(rst), .inc_i(w_ar_hs), .dec_i(w_r_last_hs),
        .cnt_o(w_rd_cnt), .zero_o(w_rd_zero), .full_o(w_rd_full)
    );
    axi_mux_out_cnt #(.WIDTH(CW), .MAX(MAX_OUTSTANDING)) u_b_cnt (
        .clk(clk), .rst(rst), .inc_i(w_aw_hs), .dec_i(w_b_hs),
        .cnt_o(w_b_cnt), .zero_o(w_b_zero), .full_o(w_b_full)
    );
    axi_mux_out_cnt #(.WIDTH(CW), .MAX(MAX_OUTSTANDING)) u_w_cnt (
        .clk(clk), .rst(rst), .inc_i(w_aw_hs), .dec_i(w_w_last_hs),
        .cnt_o(w_w_cnt), .zero_o(w_w_zero), .full_o(w_w_full)
    );

    // Range check uses the whole data word so oversized values never alias.
    assign w_sr_hit  = sr_req.valid && (sr_req.addr == SR_ADDR);
    assign w_sel_wr  = w_sr_hit && sr_req.write && (sr_req.data < SR_DW'(N_MASTERS));
    assign w_new_sel = sr_req.data[SELW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            cur_sel_q    <= SELW'(RESET_SEL);
            pend_sel_q   <= SELW'(RESET_SEL);
            pend_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (w_sel_wr && (w_new_sel != cur_sel_q)) begin
                        pend_sel_q   <= w_new_sel;
                        pend_valid_q <= 1'b1;
                        state_q      <= DRAIN;
                        busy_q       <= 1'b1;
                    end else if (pend_valid_q) begin
                        state_q <= DRAIN;
                        busy_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (w_sel_wr) begin
                        pend_sel_q   <= w_new_sel;
                        pend_valid_q <= 1'b1;
                    end
                    if (w_drained) begin
                        state_q <= SWITCH;
                    end
                end
                SWITCH: begin
                    // A write landing here becomes the next pending switch.
                    cur_sel_q    <= pend_sel_q;
                    pend_valid_q <= w_sel_wr;
                    if (w_sel_wr) begin
                        pend_sel_q <= w_new_sel;
                    end
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cur_sel = cur_sel_q;
    assign busy    = busy_q;

`ifdef AXI_MUX_NM_STATUS_EN
    SoftRegResp sr_resp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_resp_q <= '0;
        end else begin
            sr_resp_q.valid <= w_sr_hit && !sr_req.write;
            sr_resp_q.data  <= SR_DW'({busy_q, w_rd_cnt, w_b_cnt, w_w_cnt, cur_sel_q});
        end
    end

    assign sr_resp = sr_resp_q;
`else
    logic w_unused_status;
    assign w_unused_status = ^{w_rd_cnt, w_b_cnt, w_w_cnt};
    assign sr_resp = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_mux_nm.sv
// ============================================================================
// Module      : tb_axi_mux_nm
// Description : Directed self-checking bench for axi_mux_nm (N=4, limit 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_mux_nm;
    import axi_mux_nm_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    SoftRegReq  sr_req;
    SoftRegResp sr_resp;
    logic [1:0] cur_sel;
    logic       busy;
    int         checks   = 0;
    int         failures = 0;

    axi_bus_t m_if [N] ();
    axi_bus_t s_if ();

    logic        m_arvalid [N];
    logic [31:0] m_araddr  [N];
    logic [7:0]  m_arlen   [N];
    logic        m_rready  [N];
    logic        m_awvalid [N];
    logic        m_wvalid  [N];
    logic        m_wlast   [N];
    logic        m_bready  [N];
    logic        m_arready [N];
    logic        m_rvalid  [N];
    logic [31:0] m_rdata   [N];
    logic        m_awready [N];
    logic        m_wready  [N];
    logic        m_bvalid  [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_m
            assign m_if[g].arvalid = m_arvalid[g];
            assign m_if[g].araddr  = m_araddr[g];
            assign m_if[g].arlen   = m_arlen[g];
            assign m_if[g].arid    = '0;
            assign m_if[g].rready  = m_rready[g];
            assign m_if[g].awvalid = m_awvalid[g];
            assign m_if[g].awaddr  = '0;
            assign m_if[g].awlen   = '0;
            assign m_if[g].awid    = '0;
            assign m_if[g].wvalid  = m_wvalid[g];
            assign m_if[g].wdata   = 32'hA0 + g;
            assign m_if[g].wstrb   = '1;
            assign m_if[g].wlast   = m_wlast[g];
            assign m_if[g].bready  = m_bready[g];
            assign m_arready[g] = m_if[g].arready;
            assign m_rvalid[g]  = m_if[g].rvalid;
            assign m_rdata[g]   = m_if[g].rdata;
            assign m_awready[g] = m_if[g].awready;
            assign m_wready[g]  = m_if[g].wready;
            assign m_bvalid[g]  = m_if[g].bvalid;
        end
    endgenerate

    axi_mux_nm #(
        .N_MASTERS(N), .SR_ADDR(32'h10), .MAX_OUTSTANDING(2), .RESET_SEL(0)
    ) dut (
        .clk(clk), .rst(rst), .sr_req(sr_req), .sr_resp(sr_resp),
        .axi_m(m_if), .axi_s(s_if), .cur_sel(cur_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic sr_wr(input logic [31:0] d);
        sr_req.valid = 1'b1;
        sr_req.write = 1'b1;
        sr_req.addr  = 32'h10;
        sr_req.data  = d;
        tick();
        sr_req = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0;
        rst    = 1'b1;
        sr_req = '0;
        for (int i = 0; i < N; i++) begin
            m_arvalid[i] = 1'b0; m_araddr[i] = '0; m_arlen[i] = '0;
            m_rready[i] = 1'b0; m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0;
            m_wlast[i] = 1'b0; m_bready[i] = 1'b0;
        end
        s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = '0;
        s_if.rid = '0; s_if.rlast = 1'b0; s_if.awready = 1'b0; s_if.wready = 1'b0;
        s_if.bvalid = 1'b0; s_if.bresp = '0; s_if.bid = '0;

        // Reset state
        #2;
        chk1("rst_busy", busy, 1'b0);
        chk("rst_cur_sel", 32'(cur_sel), 0);
        chk1("rst_sr_valid", sr_resp.valid, 1'b0);
        tick(); tick();
        rst = 1'b0;

        // Port 0 read, addr 'h100 len 3
        m_arvalid[0] = 1'b1; m_araddr[0] = 32'h100; m_arlen[0] = 8'd3;
        s_if.arready = 1'b1;
        #1;
        chk1("ar_fwd_valid", s_if.arvalid, 1'b1);
        chk("ar_fwd_addr", s_if.araddr, 32'h100);
        chk("ar_fwd_len", 32'(s_if.arlen), 3);
        chk1("ar_rdy_sel", m_arready[0], 1'b1);
        chk1("ar_rdy_unsel", m_arready[1], 1'b0);
        tick();
        m_arvalid[0] = 1'b0;
        m_rready[0] = 1'b1; m_rready[1] = 1'b1;
        s_if.rvalid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s_if.rdata = 32'h1000 + b;
            s_if.rlast = (b == 3);
            #1;
            chk1("r_valid_p0", m_rvalid[0], 1'b1);
            chk("r_data_p0", m_rdata[0], 32'h1000 + b);
            chk1("r_valid_p1", m_rvalid[1], 1'b0);
            chk("r_data_p2", m_rdata[2], 32'h0);
            tick();
        end
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;

        // AR limit: two accepted, third gated
        m_arvalid[0] = 1'b1; m_arlen[0] = 8'd0;
        tick(); tick();
        chk1("ar_full_rdy", m_arready[0], 1'b0);
        chk1("ar_full_fwd", s_if.arvalid, 1'b0);
        m_arvalid[0] = 1'b0;
        s_if.rvalid = 1'b1; s_if.rlast = 1'b1;
        tick(); tick();
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;

        // Idle switch to port 2: busy cycles 1-2, routed at cycle 3
        sr_wr(32'd2);
        chk1("sw_busy_c1", busy, 1'b1);
        chk("sw_sel_c1", 32'(cur_sel), 0);
        m_arvalid[2] = 1'b1; m_araddr[2] = 32'h200;
        #1;
        chk1("sw_ar_gate_c1", m_arready[2], 1'b0);
        chk1("sw_ar_fwd_c1", s_if.arvalid, 1'b0);
        tick();
        chk1("sw_busy_c2", busy, 1'b1);
        tick();
        chk1("sw_busy_c3", busy, 1'b0);
        chk("sw_sel_c3", 32'(cur_sel), 2);
        chk1("sw_ar_rdy_c3", m_arready[2], 1'b1);
        chk("sw_ar_addr_c3", s_if.araddr, 32'h200);
        tick();
        m_arvalid[2] = 1'b0;
        s_if.rvalid = 1'b1; s_if.rlast = 1'b1; m_rready[2] = 1'b1;
        #1;
        chk1("p2_rvalid", m_rvalid[2], 1'b1);
        chk1("p0_rvalid_off", m_rvalid[0], 1'b0);
        tick();
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;

        // No-op writes in RUN: same port, out of range
        sr_wr(32'd2);
        chk1("sr_same_noop", busy, 1'b0);
        sr_wr(32'd4);
        chk1("sr_oor_noop", busy, 1'b0);

        // Switch back to 0, then port 0 len-7 read in flight while switching to 1
        sr_wr(32'd0);
        tick(); tick();
        chk("back_to_p0", 32'(cur_sel), 0);
        m_arvalid[0] = 1'b1; m_arlen[0] = 8'd7;
        tick();
        m_arvalid[0] = 1'b0;
        sr_wr(32'd1);
        m_arvalid[0] = 1'b1;
        #1;
        chk1("drain_ar_gate", m_arready[0], 1'b0);
        chk1("drain_ar_fwd", s_if.arvalid, 1'b0);
        m_arvalid[0] = 1'b0;
        seen0 = 0;
        s_if.rvalid = 1'b1;
        for (int b = 0; b < 8; b++) begin
            s_if.rlast = (b == 7);
            #1;
            if (m_rvalid[0] && !m_rvalid[1] && busy && (cur_sel == 2'd0)) seen0++;
            tick();
        end
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
        chk("drain_r_beats", 32'(seen0), 8);
        chk1("no_early_switch_busy", busy, 1'b1);
        chk("no_early_switch_sel", 32'(cur_sel), 0);
        tick();
        chk1("switch_busy", busy, 1'b1);
        tick();
        chk("after_drain_sel", 32'(cur_sel), 1);
        chk1("after_drain_busy", busy, 1'b0);

        // Status read with sel=1, idle
        sr_req.valid = 1'b1; sr_req.write = 1'b0; sr_req.addr = 32'h10; sr_req.data = '0;
        #1;
        chk1("st_same_cycle", sr_resp.valid, 1'b0);
        tick();
        sr_req = '0;
`ifdef AXI_MUX_NM_STATUS_EN
        chk1("st_valid", sr_resp.valid, 1'b1);
        chk("st_data", sr_resp.data, 32'h1);
`else
        chk1("st_off_valid", sr_resp.valid, 1'b0);
        chk("st_off_data", sr_resp.data, 32'h0);
`endif
        tick();
        chk1("st_pulse_end", sr_resp.valid, 1'b0);

        // Writes during DRAIN: 2 (enter), 5 ignored, 3 wins, 4 ignored
        m_arvalid[1] = 1'b1; m_arlen[1] = 8'd0;
        tick();
        m_arvalid[1] = 1'b0;
        sr_wr(32'd2);
        sr_wr(32'd5);
        sr_wr(32'd3);
        sr_wr(32'd4);
        chk1("drain_held_busy", busy, 1'b1);
        s_if.rvalid = 1'b1; s_if.rlast = 1'b1; m_rready[1] = 1'b1;
        #1;
        chk1("drain_r_old_port", m_rvalid[1], 1'b1);
        tick();
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
        tick(); tick();
        chk("latest_sel", 32'(cur_sel), 3);
        chk1("latest_busy", busy, 1'b0);

        // AW limit on port 3 and W gating
        m_wvalid[3] = 1'b1; m_wlast[3] = 1'b1; s_if.wready = 1'b1;
        #1;
        chk1("w_before_aw_rdy", m_wready[3], 1'b0);
        chk1("w_before_aw_fwd", s_if.wvalid, 1'b0);
        m_wvalid[3] = 1'b0;
        m_awvalid[3] = 1'b1; s_if.awready = 1'b1;
        #1;
        chk1("aw1_rdy", m_awready[3], 1'b1);
        chk1("aw1_fwd", s_if.awvalid, 1'b1);
        tick();
        chk1("aw2_rdy", m_awready[3], 1'b1);
        tick();
        chk1("aw3_gated", m_awready[3], 1'b0);
        chk1("aw3_fwd_gated", s_if.awvalid, 1'b0);
        m_wvalid[3] = 1'b1;
        #1;
        chk1("w_after_aw_rdy", m_wready[3], 1'b1);
        chk1("w_after_aw_fwd", s_if.wvalid, 1'b1);
        tick();
        m_wvalid[3] = 1'b0;
        s_if.bvalid = 1'b1; m_bready[3] = 1'b1;
        #1;
        chk1("b_valid_p3", m_bvalid[3], 1'b1);
        chk1("b_valid_p0", m_bvalid[0], 1'b0);
        chk1("aw3_gated_b_cycle", m_awready[3], 1'b0);
        tick();
        s_if.bvalid = 1'b0;
        #1;
        chk1("aw3_after_b", m_awready[3], 1'b1);
        tick();
        m_awvalid[3] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
